// File: rtl/cus19_integer_file.sv
// cus19_integer_file: byte-wide register file with two combinational read ports and one
// pair-write port (low byte to addr, high byte to addr+1), with same-cycle write forwarding.
module cus19_integer_file #(
    parameter int Data_Width     = 8,
    parameter int Reg_Addr_Width = 4
) (
    input  logic                      clk_in,
    input  logic                      rst_in,
    input  logic [Reg_Addr_Width-1:0] rs1_addr_in,
    input  logic [Reg_Addr_Width-1:0] rs2_addr_in,
    input  logic                      wr_en_in,
    input  logic [Reg_Addr_Width-1:0] wr_addr_in,
    input  logic [2*Data_Width-1:0]   wr_data_in,
    output logic [Data_Width-1:0]     rs1_out,
    output logic [Data_Width-1:0]     rs2_out
);
    localparam int Num_Regs = 2 ** Reg_Addr_Width;

    logic [Data_Width-1:0]     r_regs [Num_Regs];
    logic [Reg_Addr_Width-1:0] w_wr_addr_hi;
    logic [Data_Width-1:0]     w_wr_lo;
    logic [Data_Width-1:0]     w_wr_hi;
    logic                      w_fwd;

    // Pair address wraps naturally through the fixed-width add
    assign w_wr_addr_hi = wr_addr_in + Reg_Addr_Width'(1);
    assign w_wr_lo      = wr_data_in[Data_Width-1:0];
    assign w_wr_hi      = wr_data_in[2*Data_Width-1:Data_Width];
    assign w_fwd        = rst_in & wr_en_in;

    always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in) begin
            for (int i = 0; i < Num_Regs; i++) r_regs[i] <= '0;
        end else if (wr_en_in) begin
            r_regs[wr_addr_in]   <= w_wr_lo;
            r_regs[w_wr_addr_hi] <= w_wr_hi;
        end
    end

    assign rs1_out = !rst_in ? '0 :
                     (w_fwd && rs1_addr_in == wr_addr_in)   ? w_wr_lo :
                     (w_fwd && rs1_addr_in == w_wr_addr_hi) ? w_wr_hi : r_regs[rs1_addr_in];
    assign rs2_out = !rst_in ? '0 :
                     (w_fwd && rs2_addr_in == wr_addr_in)   ? w_wr_lo :
                     (w_fwd && rs2_addr_in == w_wr_addr_hi) ? w_wr_hi : r_regs[rs2_addr_in];
endmodule

// File: tb/tb_cus19_integer_file.sv
// tb_cus19_integer_file: directed vector table plus randomized traffic checked against
// an array model of the register file with forwarding.
module tb_cus19_integer_file;
    logic        clk_in = 1'b0;
    logic        rst_in;
    logic [3:0]  rs1_addr_in, rs2_addr_in, wr_addr_in;
    logic        wr_en_in;
    logic [15:0] wr_data_in;
    logic [7:0]  rs1_out, rs2_out;

    int errors = 0;
    int checks = 0;
    logic [7:0] mdl [16];

    typedef struct {
        logic        we;
        logic [3:0]  wa;
        logic [15:0] wd;
        logic [3:0]  a1;
        logic [3:0]  a2;
        logic [7:0]  e1;
        logic [7:0]  e2;
    } vec_t;

    vec_t vecs [$];

    cus19_integer_file #(.Data_Width(8), .Reg_Addr_Width(4)) dut (
        .clk_in(clk_in), .rst_in(rst_in),
        .rs1_addr_in(rs1_addr_in), .rs2_addr_in(rs2_addr_in),
        .wr_en_in(wr_en_in), .wr_addr_in(wr_addr_in), .wr_data_in(wr_data_in),
        .rs1_out(rs1_out), .rs2_out(rs2_out)
    );

    always #5 clk_in = ~clk_in;

    function automatic vec_t mk(int we, int wa, int wd, int a1, int a2, int e1, int e2);
        vec_t v;
        v.we = 1'(we); v.wa = 4'(wa); v.wd = 16'(wd);
        v.a1 = 4'(a1); v.a2 = 4'(a2); v.e1 = 8'(e1); v.e2 = 8'(e2);
        return v;
    endfunction

    // Expected read value from the spec rules: reset -> 0, forward low/high byte, else stored
    function automatic logic [7:0] expect_rd(logic [3:0] a);
        if (!rst_in) return 8'h00;
        if (wr_en_in && a == wr_addr_in) return wr_data_in[7:0];
        if (wr_en_in && int'(a) == (int'(wr_addr_in) + 1) % 16) return wr_data_in[15:8];
        return mdl[a];
    endfunction

    task automatic chk(string name, logic [7:0] act, logic [7:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic drive(logic we, logic [3:0] wa, logic [15:0] wd, logic [3:0] a1, logic [3:0] a2);
        wr_en_in = we; wr_addr_in = wa; wr_data_in = wd;
        rs1_addr_in = a1; rs2_addr_in = a2;
    endtask

    // Clock edge plus model commit; returns at posedge+1
    task automatic edge_commit();
        logic w;
        logic [3:0] wa;
        logic [15:0] wd;
        w = rst_in && wr_en_in; wa = wr_addr_in; wd = wr_data_in;
        @(posedge clk_in);
        if (w) begin
            mdl[wa] = wd[7:0];
            mdl[(int'(wa) + 1) % 16] = wd[15:8];
        end
        #1;
    endtask

    task automatic clear_model();
        for (int i = 0; i < 16; i++) mdl[i] = 8'h00;
    endtask

    initial begin
        rst_in = 1'b0;
        drive(1'b1, 4'd3, 16'hFFFF, 4'd3, 4'd4);
        clear_model();
        #2;
        chk("reset_rs1", rs1_out, 8'h00);
        chk("reset_rs2", rs2_out, 8'h00);
        @(posedge clk_in); #1;
        chk("reset_hold_rs1", rs1_out, 8'h00);
        chk("reset_hold_rs2", rs2_out, 8'h00);
        rst_in = 1'b1;
        drive(1'b0, 4'd0, 16'h0000, 4'd3, 4'd4);
        #1;
        chk("post_reset_rs1", rs1_out, 8'h00);
        chk("post_reset_rs2", rs2_out, 8'h00);
        edge_commit();

        vecs.push_back(mk(1,  2, 'hABCD, 2, 3, 'hCD, 'hAB));
        vecs.push_back(mk(0,  0, 'h0000, 2, 3, 'hCD, 'hAB));
        vecs.push_back(mk(1,  5, 'h1122, 5, 6, 'h22, 'h11));
        vecs.push_back(mk(0,  0, 'h0000, 5, 6, 'h22, 'h11));
        vecs.push_back(mk(1,  7, 'h55AA, 7, 8, 'hAA, 'h55));
        vecs.push_back(mk(0,  0, 'h0000, 7, 8, 'hAA, 'h55));
        vecs.push_back(mk(0,  0, 'h0000, 2, 6, 'hCD, 'h11));
        vecs.push_back(mk(1, 15, 'h9F3C, 0, 15, 'h9F, 'h3C));
        vecs.push_back(mk(0,  0, 'h0000, 0, 15, 'h9F, 'h3C));
        vecs.push_back(mk(0,  2, 'h0000, 2, 3, 'hCD, 'hAB));
        vecs.push_back(mk(0,  2, 'h0000, 2, 3, 'hCD, 'hAB));
        vecs.push_back(mk(0,  2, 'h0000, 2, 3, 'hCD, 'hAB));
        vecs.push_back(mk(1,  3, 'h7766, 4, 4, 'h77, 'h77));
        vecs.push_back(mk(0,  0, 'h0000, 3, 2, 'h66, 'hCD));
        vecs.push_back(mk(1,  9, 'h0102, 8, 7, 'h55, 'hAA));
        vecs.push_back(mk(0,  0, 'h0000, 9, 10, 'h02, 'h01));
        vecs.push_back(mk(0,  0, 'h0000, 5, 6, 'h22, 'h11));

        foreach (vecs[i]) begin
            drive(vecs[i].we, vecs[i].wa, vecs[i].wd, vecs[i].a1, vecs[i].a2);
            #1;
            chk($sformatf("vec%0d_rs1", i), rs1_out, vecs[i].e1);
            chk($sformatf("vec%0d_rs2", i), rs2_out, vecs[i].e2);
            edge_commit();
        end

        // Async reset mid-cycle wipes a freshly written pair and suppresses forwarding
        drive(1'b1, 4'd4, 16'hFFFF, 4'd4, 4'd5);
        edge_commit();
        drive(1'b0, 4'd0, 16'h0000, 4'd4, 4'd5);
        #1;
        chk("pair4_rs1", rs1_out, 8'hFF);
        chk("pair4_rs2", rs2_out, 8'hFF);
        drive(1'b1, 4'd4, 16'hFFFF, 4'd4, 4'd5);
        rst_in = 1'b0;
        clear_model();
        #1;
        chk("async_rst_rs1", rs1_out, 8'h00);
        chk("async_rst_rs2", rs2_out, 8'h00);
        edge_commit();
        chk("rst_over_write_rs1", rs1_out, 8'h00);
        chk("rst_over_write_rs2", rs2_out, 8'h00);
        rst_in = 1'b1;
        drive(1'b0, 4'd4, 16'hFFFF, 4'd4, 4'd2);
        #1;
        chk("deassert_rs1", rs1_out, 8'h00);
        chk("deassert_rs2", rs2_out, 8'h00);
        drive(1'b1, 4'd1, 16'hBEEF, 4'd1, 4'd2);
        edge_commit();
        drive(1'b0, 4'd0, 16'h0000, 4'd1, 4'd2);
        #1;
        chk("first_edge_wr_rs1", rs1_out, 8'hEF);
        chk("first_edge_wr_rs2", rs2_out, 8'hBE);
        edge_commit();

        for (int n = 0; n < 400; n++) begin
            if ($urandom_range(0, 39) == 0) begin
                drive(1'($urandom), 4'($urandom), 16'($urandom), 4'($urandom), 4'($urandom));
                rst_in = 1'b0;
                clear_model();
                #1;
                chk("rnd_rst_rs1", rs1_out, 8'h00);
                chk("rnd_rst_rs2", rs2_out, 8'h00);
                #1;
                rst_in = 1'b1;
                #1;
            end
            drive(1'($urandom_range(0, 2) != 0), 4'($urandom), 16'($urandom),
                  4'($urandom), 4'($urandom));
            if ($urandom_range(0, 3) == 0) rs2_addr_in = wr_addr_in + 4'd1;
            #1;
            chk($sformatf("rnd%0d_rs1", n), rs1_out, expect_rd(rs1_addr_in));
            chk($sformatf("rnd%0d_rs2", n), rs2_out, expect_rd(rs2_addr_in));
            edge_commit();
        end

        // Sweep every register against the model with writes disabled
        for (int a = 0; a < 16; a++) begin
            drive(1'b0, 4'($urandom), 16'($urandom), 4'(a), 4'(15 - a));
            #1;
            chk($sformatf("sweep%0d_rs1", a), rs1_out, mdl[a]);
            chk($sformatf("sweep%0d_rs2", a), rs2_out, mdl[15 - a]);
            edge_commit();
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
